// File: rtl/ntt_pkg.sv
// Types and width helper shared by the forward and inverse NTT sequencers.
package ntt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WORK  = 2'd1,
    ST_SCALE = 2'd2,
    ST_DONE  = 2'd3
  } ntt_state_e;

  // Loop counters need one bit beyond the address so that m = N is representable.
  function automatic int unsigned cnt_w(input int unsigned n_log);
    return n_log + 1;
  endfunction

endpackage

// File: rtl/ntt_loop_iter.sv
// Stage/k/j nested butterfly counter; half_m shrinks (inverse) or grows (forward) per stage.
module ntt_loop_iter
  import ntt_pkg::*;
#(
  parameter int unsigned N_LOG      = 12,
  parameter bit          DECREASING = 1'b1,
  localparam int unsigned W         = cnt_w(N_LOG)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         adv_i,
  output logic [W-1:0] k_o,
  output logic [W-1:0] j_o,
  output logic [W-1:0] half_m_o,
  output logic [W-1:0] w_stride_o,
  output logic         last_o_c
);

  localparam int unsigned N = 1 << N_LOG;

  logic [W-1:0] stage_q, stage_d;
  logic [W-1:0] k_q, k_d;
  logic [W-1:0] j_q, j_d;
  logic [W-1:0] m_q, m_d;
  logic [W-1:0] half_m_q, half_m_d;
  logic [W-1:0] w_stride_q, w_stride_d;
  logic [W-1:0] k_plus_m;
  logic [W-1:0] half_m_last;

  assign k_plus_m    = k_q + m_q;
  assign half_m_last = half_m_q - W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q    <= '0;
      k_q        <= '0;
      j_q        <= '0;
      m_q        <= '0;
      half_m_q   <= '0;
      w_stride_q <= '0;
    end else begin
      stage_q    <= stage_d;
      k_q        <= k_d;
      j_q        <= j_d;
      m_q        <= m_d;
      half_m_q   <= half_m_d;
      w_stride_q <= w_stride_d;
    end
  end

  // j innermost, then k across groups, then stage.
  always_comb begin
    stage_d    = stage_q;
    k_d        = k_q;
    j_d        = j_q;
    m_d        = m_q;
    half_m_d   = half_m_q;
    w_stride_d = w_stride_q;
    if (load_i) begin
      stage_d = W'(1);
      k_d     = '0;
      j_d     = '0;
      if (DECREASING) begin
        m_d        = W'(N);
        half_m_d   = W'(N / 2);
        w_stride_d = W'(1);
      end else begin
        m_d        = W'(2);
        half_m_d   = W'(1);
        w_stride_d = W'(N / 2);
      end
    end else if (adv_i) begin
      if (j_q < half_m_last) begin
        j_d = j_q + W'(1);
      end else begin
        j_d = '0;
        if (k_plus_m < W'(N)) begin
          k_d = k_plus_m;
        end else begin
          k_d = '0;
          if (stage_q < W'(N_LOG)) begin
            stage_d = stage_q + W'(1);
            if (DECREASING) begin
              m_d        = m_q >> 1;
              half_m_d   = half_m_q >> 1;
              w_stride_d = w_stride_q << 1;
            end else begin
              m_d        = m_q << 1;
              half_m_d   = half_m_q << 1;
              w_stride_d = w_stride_q >> 1;
            end
          end
        end
      end
    end
  end

  assign last_o_c = (j_q == half_m_last) && (k_plus_m >= W'(N)) && (stage_q == W'(N_LOG));

  assign k_o        = k_q;
  assign j_o        = j_q;
  assign half_m_o   = half_m_q;
  assign w_stride_o = w_stride_q;

endmodule

// File: rtl/intt_control.sv
// Inverse-NTT address sequencer: DIF butterfly triples, optional N^-1 scaling pass, valid/ready output.
module intt_control
  import ntt_pkg::*;
#(
  parameter int unsigned N_LOG    = 12,
  parameter int unsigned N        = 4096,
  parameter bit          SCALE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ready,
  output logic [N_LOG-1:0] addr_u,
  output logic [N_LOG-1:0] addr_v,
  output logic [N_LOG-1:0] addr_w,
  output logic             scale,
  output logic             valid,
  output logic             done
);

  localparam int unsigned W = cnt_w(N_LOG);

  ntt_state_e       state_q, state_d;
  logic [W-1:0]     i_q, i_d;
  logic [N_LOG-1:0] addr_u_q, addr_u_d;
  logic [N_LOG-1:0] addr_v_q, addr_v_d;
  logic [N_LOG-1:0] addr_w_q, addr_w_d;
  logic             scale_q, scale_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic             adv;
  logic             iter_load;
  logic             iter_adv;
  logic [W-1:0]     k;
  logic [W-1:0]     j;
  logic [W-1:0]     half_m;
  logic [W-1:0]     w_stride;
  logic             iter_last;

  assign adv = !valid_q || ready;

  ntt_loop_iter #(
    .N_LOG      (N_LOG),
    .DECREASING (1'b1)
  ) u_iter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (iter_load),
    .adv_i      (iter_adv),
    .k_o        (k),
    .j_o        (j),
    .half_m_o   (half_m),
    .w_stride_o (w_stride),
    .last_o_c   (iter_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      i_q      <= '0;
      addr_u_q <= '0;
      addr_v_q <= '0;
      addr_w_q <= '0;
      scale_q  <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      addr_u_q <= addr_u_d;
      addr_v_q <= addr_v_d;
      addr_w_q <= addr_w_d;
      scale_q  <= scale_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  // Output registers only reload on adv, so a stalled beat stays put.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    addr_u_d  = addr_u_q;
    addr_v_d  = addr_v_q;
    addr_w_d  = addr_w_q;
    scale_d   = scale_q;
    valid_d   = valid_q;
    done_d    = done_q;
    iter_load = 1'b0;
    iter_adv  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (start) begin
          iter_load = 1'b1;
          state_d   = ST_WORK;
        end
      end
      ST_WORK: begin
        if (adv) begin
          addr_u_d = N_LOG'(k + j);
          addr_v_d = N_LOG'(k + j + half_m);
          addr_w_d = N_LOG'(j * w_stride);
          scale_d  = 1'b0;
          valid_d  = 1'b1;
          iter_adv = 1'b1;
          if (iter_last) begin
            if (SCALE_EN) begin
              i_d     = '0;
              state_d = ST_SCALE;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_SCALE: begin
        if (adv) begin
          addr_u_d = N_LOG'(i_q);
          addr_v_d = '0;
          addr_w_d = '0;
          scale_d  = 1'b1;
          valid_d  = 1'b1;
          if (i_q == W'(N - 1)) begin
            state_d = ST_DONE;
          end else begin
            i_d = i_q + W'(1);
          end
        end
      end
      ST_DONE: begin
        // Drain the final beat first; only then may a released start return to IDLE.
        if (valid_q) begin
          if (ready) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end else if (!start) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign addr_u = addr_u_q;
  assign addr_v = addr_v_q;
  assign addr_w = addr_w_q;
  assign scale  = scale_q;
  assign valid  = valid_q;
  assign done   = done_q;

endmodule
